// File: rtl/b10_vote_round_sched.sv
// rtl/b10_vote_round_sched.sv - round-robin vote collection and bitwise majority publish scheduler
//
// One START runs one voting round: stations are granted one at a time
// (round-robin), each granted vote is tallied per bit, and the strict
// bitwise majority is offered to the receiver over an RTR/CTR handshake.
//
// Ports:
//   CLOCK        in   system clock, rising edge
//   RESET        in   synchronous, active-high reset
//   START        in   begin a round (honoured only in IDLE)
//   RTS          in   [N_STATION] per-station request-to-send
//   V_IN         in   [N_STATION*VOTE_W] votes, station i at [i*VOTE_W +: VOTE_W]
//   CTS          out  [N_STATION] registered grant, one-hot or zero
//   RTR          in   receiver ready-to-receive
//   CTR          out  registered result valid
//   V_OUT        out  [VOTE_W] majority result, held until next publish or reset
//   BUSY         out  high outside IDLE
//   TIMEOUT_ERR  out  last published round was forced by the idle timeout
//   ROUND_CNT    out  [8] completed-round counter, wraps
module b10_vote_round_sched #(
  parameter int N_STATION = 4,
  parameter int VOTE_W    = 4,
  parameter int TIMEOUT   = 15
) (
  input  logic                          CLOCK,
  input  logic                          RESET,
  input  logic                          START,
  input  logic [N_STATION-1:0]          RTS,
  input  logic [N_STATION*VOTE_W-1:0]   V_IN,
  output logic [N_STATION-1:0]          CTS,
  input  logic                          RTR,
  output logic                          CTR,
  output logic [VOTE_W-1:0]             V_OUT,
  output logic                          BUSY,
  output logic                          TIMEOUT_ERR,
  output logic [7:0]                    ROUND_CNT
);

  localparam int PW = $clog2(N_STATION);
  // A tally can reach N_STATION, so it needs clog2(N_STATION+1) bits.
  localparam int TW = $clog2(N_STATION + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ARB       = 3'd1;
  localparam logic [2:0] S_GRANT     = 3'd2;
  localparam logic [2:0] S_WAIT_DROP = 3'd3;
  localparam logic [2:0] S_PUBLISH   = 3'd4;

  logic [2:0]                 state;
  logic [N_STATION-1:0]       cts_q;
  logic [N_STATION-1:0]       served;
  logic [PW-1:0]              rr_ptr;
  logic [PW-1:0]              gnt_idx;
  logic [TW-1:0]              served_cnt;
  logic [VOTE_W-1:0][TW-1:0]  tally;
  logic [7:0]                 idle_cnt;
  logic [7:0]                 round_cnt;
  logic                       ctr_q;
  logic                       terr_q;
  logic [VOTE_W-1:0]          vout_q;

  // Per-station vote slices, selected by the granted index.
  logic [VOTE_W-1:0] slice [N_STATION];
  logic [VOTE_W-1:0] slice_sel;

  genvar gi;
  for (gi = 0; gi < N_STATION; gi++) begin : g_slice
    assign slice[gi] = V_IN[gi*VOTE_W +: VOTE_W];
  end

  assign slice_sel = slice[gnt_idx];

  // Stations already counted this round are masked out of arbitration.
  logic [N_STATION-1:0] eligible;
  logic                 all_served;

  assign eligible   = RTS & ~served;
  assign all_served = &served;

  // Round-robin pick: scan from rr_ptr upward with wrap. The scan runs
  // from the farthest offset down so the nearest eligible index wins.
  logic          pick_found;
  logic [PW-1:0] pick_idx;
  logic [PW-1:0] scan_pw;
  int            scan_idx;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = 0;
    scan_pw    = '0;
    for (int k = N_STATION - 1; k >= 0; k--) begin
      scan_idx = int'(rr_ptr) + k;
      if (scan_idx >= N_STATION) begin
        scan_idx = scan_idx - N_STATION;
      end
      scan_pw = PW'(scan_idx);
      if (eligible[scan_pw]) begin
        pick_found = 1'b1;
        pick_idx   = scan_pw;
      end
    end
  end

  logic [N_STATION-1:0] pick_onehot;
  assign pick_onehot = {{(N_STATION-1){1'b0}}, 1'b1} << pick_idx;

  // Pointer moves past the station just handled, whether it voted or withdrew.
  logic [PW-1:0] rr_next;
  assign rr_next = (gnt_idx == PW'(N_STATION - 1)) ? '0 : gnt_idx + 1'b1;

  // Strict majority: 2*tally > served_cnt, so a tie or an empty round gives 0.
  logic [VOTE_W-1:0] majority;

  always_comb begin
    majority = '0;
    for (int j = 0; j < VOTE_W; j++) begin
      majority[j] = ({tally[j], 1'b0} > {1'b0, served_cnt});
    end
  end

  logic [7:0] idle_nxt;
  assign idle_nxt = idle_cnt + 8'd1;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state      <= S_IDLE;
      cts_q      <= '0;
      served     <= '0;
      rr_ptr     <= '0;
      gnt_idx    <= '0;
      served_cnt <= '0;
      tally      <= '0;
      idle_cnt   <= '0;
      round_cnt  <= '0;
      ctr_q      <= 1'b0;
      terr_q     <= 1'b0;
      vout_q     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // rr_ptr deliberately survives across rounds for fairness.
          if (START) begin
            state      <= S_ARB;
            tally      <= '0;
            served     <= '0;
            served_cnt <= '0;
            idle_cnt   <= '0;
            terr_q     <= 1'b0;
          end
        end

        S_ARB: begin
          if (all_served) begin
            state  <= S_PUBLISH;
            ctr_q  <= 1'b1;
            vout_q <= majority;
          end else if (pick_found) begin
            state    <= S_GRANT;
            gnt_idx  <= pick_idx;
            cts_q    <= pick_onehot;
            idle_cnt <= '0;
          end else if (idle_nxt == 8'(TIMEOUT)) begin
            // Nobody left requesting: publish what has been collected.
            idle_cnt <= idle_nxt;
            terr_q   <= 1'b1;
            state    <= S_PUBLISH;
            ctr_q    <= 1'b1;
            vout_q   <= majority;
          end else begin
            idle_cnt <= idle_nxt;
          end
        end

        S_GRANT: begin
          if (RTS[gnt_idx]) begin
            for (int j = 0; j < VOTE_W; j++) begin
              tally[j] <= tally[j] + TW'(slice_sel[j]);
            end
            served_cnt <= served_cnt + 1'b1;
            state      <= S_WAIT_DROP;
          end else begin
            // Withdrawn before capture: not served, may re-request later.
            cts_q  <= '0;
            rr_ptr <= rr_next;
            state  <= S_ARB;
          end
        end

        S_WAIT_DROP: begin
          // Grant is held until the station releases its request.
          if (!RTS[gnt_idx]) begin
            cts_q           <= '0;
            served[gnt_idx] <= 1'b1;
            rr_ptr          <= rr_next;
            state           <= S_ARB;
          end
        end

        S_PUBLISH: begin
          if (RTR) begin
            ctr_q     <= 1'b0;
            round_cnt <= round_cnt + 8'd1;
            state     <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
          cts_q <= '0;
          ctr_q <= 1'b0;
        end
      endcase
    end
  end

  assign CTS         = cts_q;
  assign CTR         = ctr_q;
  assign V_OUT       = vout_q;
  assign BUSY        = (state != S_IDLE);
  assign TIMEOUT_ERR = terr_q;
  assign ROUND_CNT   = round_cnt;

endmodule

// File: tb/tb_b10_vote_round_sched.sv
// tb/tb_b10_vote_round_sched.sv - directed self-checking bench for b10_vote_round_sched
module tb_b10_vote_round_sched;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        START;
  logic [3:0]  RTS;
  logic [15:0] V_IN;
  logic [3:0]  CTS;
  logic        RTR;
  logic        CTR;
  logic [3:0]  V_OUT;
  logic        BUSY;
  logic        TIMEOUT_ERR;
  logic [7:0]  ROUND_CNT;

  int checks = 0;
  int fails  = 0;

  always #5 CLOCK = ~CLOCK;

  b10_vote_round_sched #(
    .N_STATION (4),
    .VOTE_W    (4),
    .TIMEOUT   (15)
  ) dut (
    .CLOCK       (CLOCK),
    .RESET       (RESET),
    .START       (START),
    .RTS         (RTS),
    .V_IN        (V_IN),
    .CTS         (CTS),
    .RTR         (RTR),
    .CTR         (CTR),
    .V_OUT       (V_OUT),
    .BUSY        (BUSY),
    .TIMEOUT_ERR (TIMEOUT_ERR),
    .ROUND_CNT   (ROUND_CNT)
  );

  task automatic tick;
    @(posedge CLOCK);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    checks++; if (CTS !== 4'b0000) begin fails++; $display("FAIL %s_cts: got %b expected 0000", tag, CTS); end
    checks++; if (CTR !== 1'b0) begin fails++; $display("FAIL %s_ctr: got %b expected 0", tag, CTR); end
    checks++; if (V_OUT !== 4'b0000) begin fails++; $display("FAIL %s_vout: got %b expected 0000", tag, V_OUT); end
    checks++; if (BUSY !== 1'b0) begin fails++; $display("FAIL %s_busy: got %b expected 0", tag, BUSY); end
    checks++; if (TIMEOUT_ERR !== 1'b0) begin fails++; $display("FAIL %s_terr: got %b expected 0", tag, TIMEOUT_ERR); end
    checks++; if (ROUND_CNT !== 8'd0) begin fails++; $display("FAIL %s_round: got %0d expected 0", tag, ROUND_CNT); end
  endtask

  // Wait for a grant, expect it on station idx, let it capture, then drop RTS.
  task automatic serve(input int idx, input string tag);
    logic [3:0] exp_cts;
    int n;
    exp_cts = 4'b0001 << idx;
    n = 0;
    while (CTS === 4'b0000 && n < 40) begin tick(); n++; end
    checks++; if (CTS !== exp_cts) begin fails++; $display("FAIL %s_grant: CTS=%b expected %b", tag, CTS, exp_cts); end
    tick();
    checks++; if (CTS !== exp_cts) begin fails++; $display("FAIL %s_hold: CTS=%b expected %b", tag, CTS, exp_cts); end
    RTS[idx[1:0]] = 1'b0;
    tick();
    checks++; if (CTS !== 4'b0000) begin fails++; $display("FAIL %s_release: CTS=%b expected 0000", tag, CTS); end
  endtask

  task automatic wait_ctr(input string tag);
    int n;
    n = 0;
    while (CTR !== 1'b1 && n < 40) begin tick(); n++; end
    checks++; if (CTR !== 1'b1) begin fails++; $display("FAIL %s_ctr_rise: got %b expected 1", tag, CTR); end
  endtask

  task automatic test_reset;
    RESET = 1'b1; START = 1'b0; RTS = 4'b0000; V_IN = 16'h0000; RTR = 1'b0;
    tick();
    tick();
    RESET = 1'b0;
    check_all_zero("reset");
  endtask

  // Votes 1010,1011,0010,1110 -> majority 1010, grants in order 0..3.
  task automatic test_full_round(input logic [7:0] exp_round);
    V_IN  = 16'b1110_0010_1011_1010;
    RTS   = 4'b1111;
    START = 1'b1;
    tick();
    START = 1'b0;
    checks++; if (BUSY !== 1'b1) begin fails++; $display("FAIL full_busy: got %b expected 1", BUSY); end
    serve(0, "full_s0");
    serve(1, "full_s1");
    serve(2, "full_s2");
    serve(3, "full_s3");
    wait_ctr("full");
    checks++; if (V_OUT !== 4'b1010) begin fails++; $display("FAIL full_vout: got %b expected 1010", V_OUT); end
    checks++; if (TIMEOUT_ERR !== 1'b0) begin fails++; $display("FAIL full_terr: got %b expected 0", TIMEOUT_ERR); end
    checks++; if (CTS !== 4'b0000) begin fails++; $display("FAIL full_cts_pub: got %b expected 0000", CTS); end
    RTR = 1'b1;
    tick();
    RTR = 1'b0;
    checks++; if (CTR !== 1'b0) begin fails++; $display("FAIL full_ctr_fall: got %b expected 0", CTR); end
    checks++; if (ROUND_CNT !== exp_round) begin fails++; $display("FAIL full_round: got %0d expected %0d", ROUND_CNT, exp_round); end
    checks++; if (BUSY !== 1'b0) begin fails++; $display("FAIL full_idle: got %b expected 0", BUSY); end
    tick();
    checks++; if (V_OUT !== 4'b1010) begin fails++; $display("FAIL full_vout_hold: got %b expected 1010", V_OUT); end
  endtask

  // Station 1 withdraws in GRANT (pointer -> 2), then 2 and 1 request together.
  // Votes 0001,0100,0111,1111 -> bit0 3/4, bit1 2/4 tie, bit2 3/4, bit3 1/4 -> 0101.
  task automatic test_round_robin_withdraw;
    int n;
    V_IN  = 16'b1111_0111_0100_0001;
    RTS   = 4'b0010;
    START = 1'b1;
    tick();
    START = 1'b0;
    n = 0;
    while (CTS === 4'b0000 && n < 40) begin tick(); n++; end
    checks++; if (CTS !== 4'b0010) begin fails++; $display("FAIL wd_grant: CTS=%b expected 0010", CTS); end
    RTS = 4'b0000;
    tick();
    checks++; if (CTS !== 4'b0000) begin fails++; $display("FAIL wd_drop: CTS=%b expected 0000", CTS); end
    RTS = 4'b0110;
    serve(2, "rr_s2");
    serve(1, "rr_s1");
    RTS = 4'b1001;
    serve(3, "rr_s3");
    serve(0, "rr_s0");
    wait_ctr("rr");
    checks++; if (V_OUT !== 4'b0101) begin fails++; $display("FAIL rr_vout: got %b expected 0101", V_OUT); end
    RTR = 1'b1;
    tick();
    RTR = 1'b0;
    checks++; if (ROUND_CNT !== 8'd2) begin fails++; $display("FAIL rr_round: got %0d expected 2", ROUND_CNT); end
  endtask

  // Stations 3 then 0 vote (0100, 0110); 15 idle ARB cycles force publish of 0100.
  task automatic test_timeout;
    V_IN  = 16'b0100_0000_0000_0110;
    RTS   = 4'b1001;
    START = 1'b1;
    tick();
    START = 1'b0;
    serve(3, "to_s3");
    serve(0, "to_s0");
    repeat (14) tick();
    checks++; if (CTR !== 1'b0) begin fails++; $display("FAIL to_early_ctr: got %b expected 0", CTR); end
    checks++; if (TIMEOUT_ERR !== 1'b0) begin fails++; $display("FAIL to_early_terr: got %b expected 0", TIMEOUT_ERR); end
    tick();
    checks++; if (CTR !== 1'b1) begin fails++; $display("FAIL to_ctr: got %b expected 1", CTR); end
    checks++; if (TIMEOUT_ERR !== 1'b1) begin fails++; $display("FAIL to_terr: got %b expected 1", TIMEOUT_ERR); end
    checks++; if (V_OUT !== 4'b0100) begin fails++; $display("FAIL to_vout: got %b expected 0100", V_OUT); end
    RTR = 1'b1;
    tick();
    RTR = 1'b0;
    checks++; if (ROUND_CNT !== 8'd3) begin fails++; $display("FAIL to_round: got %0d expected 3", ROUND_CNT); end
    checks++; if (TIMEOUT_ERR !== 1'b1) begin fails++; $display("FAIL to_terr_hold: got %b expected 1", TIMEOUT_ERR); end
    checks++; if (BUSY !== 1'b0) begin fails++; $display("FAIL to_idle: got %b expected 0", BUSY); end
  endtask

  task automatic test_reset_mid_round;
    int n;
    V_IN  = 16'b1111_1111_1111_1111;
    RTS   = 4'b0100;
    START = 1'b1;
    tick();
    START = 1'b0;
    checks++; if (TIMEOUT_ERR !== 1'b0) begin fails++; $display("FAIL mr_terr_clear: got %b expected 0", TIMEOUT_ERR); end
    n = 0;
    while (CTS === 4'b0000 && n < 40) begin tick(); n++; end
    checks++; if (CTS !== 4'b0100) begin fails++; $display("FAIL mr_grant: CTS=%b expected 0100", CTS); end
    tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    RTS   = 4'b0000;
    check_all_zero("midreset");
    test_full_round(8'd1);
  endtask

  task automatic test_start_in_publish;
    RTS   = 4'b0000;
    RTR   = 1'b1;
    START = 1'b1;
    tick();
    START = 1'b0;
    repeat (14) tick();
    tick();
    checks++; if (CTR !== 1'b1) begin fails++; $display("FAIL sp_ctr: got %b expected 1", CTR); end
    checks++; if (V_OUT !== 4'b0000) begin fails++; $display("FAIL sp_vout_empty: got %b expected 0000", V_OUT); end
    START = 1'b1;
    tick();
    START = 1'b0;
    checks++; if (CTR !== 1'b0) begin fails++; $display("FAIL sp_pulse: got %b expected 0", CTR); end
    checks++; if (BUSY !== 1'b0) begin fails++; $display("FAIL sp_start_ignored: BUSY=%b expected 0", BUSY); end
    checks++; if (ROUND_CNT !== 8'd2) begin fails++; $display("FAIL sp_round: got %0d expected 2", ROUND_CNT); end
    tick();
    checks++; if (BUSY !== 1'b0) begin fails++; $display("FAIL sp_still_idle: BUSY=%b expected 0", BUSY); end
  endtask

  task automatic test_round_wrap;
    int n;
    RTR = 1'b1;
    RTS = 4'b0000;
    for (int r = 0; r < 254; r++) begin
      START = 1'b1;
      tick();
      START = 1'b0;
      n = 0;
      while (BUSY === 1'b1 && n < 40) begin tick(); n++; end
      if (r == 252) begin
        checks++; if (ROUND_CNT !== 8'd255) begin fails++; $display("FAIL wrap_255: got %0d expected 255", ROUND_CNT); end
      end
    end
    checks++; if (ROUND_CNT !== 8'd0) begin fails++; $display("FAIL wrap_0: got %0d expected 0", ROUND_CNT); end
    RTR = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_round(8'd1);
    test_round_robin_withdraw();
    test_timeout();
    test_reset_mid_round();
    test_start_in_publish();
    test_round_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
